wbgpio_padctl: RTL

//   Parametrised GPIO/pad controller for the board top level: per-pin mode
//   (input, push-pull, open-drain e.g. I2C SCL/SDA), input synchronisers,

---
 rtl/wbgpio_padctl_if.sv | 21 ++
 rtl/wbgpio_padctl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wbgpio_padctl_if.sv
// Pipelined Wishbone slave bundle for the GPIO/pad controller.
interface wbgpio_padctl_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rdata;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
    input  wb_ack, wb_stall, wb_rdata
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
    output wb_ack, wb_stall, wb_rdata
  );
endinterface

// File: rtl/wbgpio_padctl.sv
// GPIO/pad controller: per-pin mode (input, push-pull, open-drain), input
// synchronisers, sticky change flags with a maskable interrupt, and a
// pipelined Wishbone register interface. Pad tristate buffers live outside.
module wbgpio_padctl #(
  parameter int          NPINS        = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] DEFAULT_OUT  = 16'hffff,
  parameter logic [31:0] DEFAULT_MODE = 32'h0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wbgpio_padctl_if.slave   wb,
  input  logic [NPINS-1:0] i_pad_in,
  output logic [NPINS-1:0] o_pad_out,
  output logic [NPINS-1:0] o_pad_oe,
  output logic             o_int
);

  localparam logic [2:0] STARTUP_CNT = 3'(SYNC_STAGES + 1);

  logic [NPINS-1:0]   sync_q [SYNC_STAGES];
  logic [NPINS-1:0]   prev_q;
  logic [NPINS-1:0]   sync_in;
  logic [NPINS-1:0]   change;
  logic [2:0]         cnt_q;

  logic [NPINS-1:0]   out_q,  out_d;
  logic [2*NPINS-1:0] mode_q, mode_d;
  logic [NPINS-1:0]   stat_q, stat_d;
  logic [NPINS-1:0]   ien_q,  ien_d;
  logic [NPINS-1:0]   stat_clr;
  logic               int_q;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        rd_mux;
  logic               acc, wr;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign change  = sync_in ^ prev_q;
  assign acc     = wb.wb_cyc & wb.wb_stb;
  assign wr      = acc & wb.wb_we;

  // Input synchroniser chain, previous-value flop and startup mask counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
      cnt_q  <= STARTUP_CNT;
    end else begin
      sync_q[0] <= i_pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_in;
      if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
    end
  end

  // Read mux over the register map; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (wb.wb_addr)
      2'd0: rd_mux[NPINS-1:0]   = sync_in;
      2'd1: rd_mux[2*NPINS-1:0] = mode_q;
      2'd2: rd_mux[NPINS-1:0]   = stat_q;
      default: rd_mux[NPINS-1:0] = ien_q;
    endcase
  end

  // Register next-state: bus writes, sticky flags (set wins over clear).
  always_comb begin
    out_d    = out_q;
    mode_d   = mode_q;
    ien_d    = ien_q;
    stat_clr = '0;
    if (wr) begin
      case (wb.wb_addr)
        2'd0: out_d = (out_q & ~wb.wb_wdata[16 +: NPINS]) |
                      (wb.wb_wdata[NPINS-1:0] & wb.wb_wdata[16 +: NPINS]);
        2'd1: mode_d   = wb.wb_wdata[2*NPINS-1:0];
        2'd2: stat_clr = wb.wb_wdata[NPINS-1:0];
        default: ien_d = wb.wb_wdata[NPINS-1:0];
      endcase
    end
    stat_d  = (stat_q & ~stat_clr) | ((cnt_q == 3'd0) ? change : '0);
    rdata_d = acc ? rd_mux : rdata_q;
  end

  // Register state, bus response and registered interrupt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q   <= DEFAULT_OUT[NPINS-1:0];
      mode_q  <= DEFAULT_MODE[2*NPINS-1:0];
      stat_q  <= '0;
      ien_q   <= '0;
      int_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      mode_q  <= mode_d;
      stat_q  <= stat_d;
      ien_q   <= ien_d;
      int_q   <= |(stat_q & ien_q);
      ack_q   <= acc;
      rdata_q <= rdata_d;
    end
  end

  // Pad drive decode; open-drain only ever drives low.
  always_comb begin
    o_pad_out = '0;
    o_pad_oe  = '0;
    for (int i = 0; i < NPINS; i++) begin
      case (mode_q[2*i +: 2])
        2'b01: begin
          o_pad_oe[i]  = 1'b1;
          o_pad_out[i] = out_q[i];
        end
        2'b10: begin
          o_pad_oe[i]  = ~out_q[i];
          o_pad_out[i] = 1'b0;
        end
        default: begin
          o_pad_oe[i]  = 1'b0;
          o_pad_out[i] = out_q[i];
        end
      endcase
    end
  end

  assign o_int       = int_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_stall = 1'b0;
  assign wb.wb_rdata = rdata_q;

endmodule
